// File: rtl/popcount_tracker_if.sv
// Stream and result bundle for popcount_tracker: mismatch vectors in, window scores and
// per-frame best position out. thresh/hit exist only with POPCOUNT_TRACKER_THRESH_EN.
interface popcount_tracker_if #(
  parameter int DATA_W  = 4000,
  parameter int POS_W   = 10,
  parameter int SCORE_W = $clog2(DATA_W + 1)
);
  logic [DATA_W-1:0]  d_in;
  logic               in_valid;
  logic               in_ready;
  logic               frame_clr;
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic [SCORE_W-1:0] best_score;
  logic [POS_W-1:0]   best_x;
  logic [POS_W-1:0]   best_y;
  logic               done;
`ifdef POPCOUNT_TRACKER_THRESH_EN
  logic [SCORE_W-1:0] thresh;
  logic               hit;

  modport master (output d_in, in_valid, frame_clr, thresh,
                  input  in_ready, score, score_valid, best_score, best_x, best_y, done, hit);
  modport slave  (input  d_in, in_valid, frame_clr, thresh,
                  output in_ready, score, score_valid, best_score, best_x, best_y, done, hit);
`else
  modport master (output d_in, in_valid, frame_clr,
                  input  in_ready, score, score_valid, best_score, best_x, best_y, done);
  modport slave  (input  d_in, in_valid, frame_clr,
                  output in_ready, score, score_valid, best_score, best_x, best_y, done);
`endif
endinterface

// File: rtl/popcount_tracker.sv
// Multi-cycle Hamming-weight scorer for a raster of window mismatch vectors; tracks the
// minimum score per frame and its (x,y). Optional threshold hit: POPCOUNT_TRACKER_THRESH_EN.
module popcount_tracker #(
  parameter int DATA_W  = 4000,
  parameter int CHUNK_W = 200,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int POS_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  popcount_tracker_if.slave bus
);

  localparam int SCORE_W = $clog2(DATA_W + 1);
  localparam int N       = DATA_W / CHUNK_W;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, UPDATE} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [SCORE_W-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [POS_W-1:0]   x_q, y_q;
  logic [SCORE_W-1:0] score_q, best_score_q;
  logic [POS_W-1:0]   best_x_q, best_y_q;
  logic               score_valid_q, done_q;
  logic [SCORE_W-1:0] chunk_pop;
  logic               last_x, last_y;

  // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < CHUNK_W; i++) chunk_pop = chunk_pop + SCORE_W'(shift_q[i]);
  end

  assign last_x = (x_q == POS_W'(IMG_W - 1));
  assign last_y = (y_q == POS_W'(IMG_H - 1));

  assign bus.in_ready = (state_q == IDLE) && !bus.frame_clr && !rst;

`ifdef POPCOUNT_TRACKER_THRESH_EN
  logic hit_q;
`endif

  // NOTE: sequential state uses non-blocking <= only; shift_q/acc_q/cnt_q are pure datapath,
  // always reloaded on acceptance, so they are deliberately left out of the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      score_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      best_score_q  <= '1;
      best_x_q      <= '0;
      best_y_q      <= '0;
      score_valid_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef POPCOUNT_TRACKER_THRESH_EN
      hit_q         <= 1'b0;
`endif
    end else begin
      score_valid_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef POPCOUNT_TRACKER_THRESH_EN
      hit_q         <= 1'b0;
`endif
      if (bus.frame_clr) begin
        // Frame restart aborts any window in flight; no result is emitted for it.
        state_q      <= IDLE;
        x_q          <= '0;
        y_q          <= '0;
        best_score_q <= '1;
        best_x_q     <= '0;
        best_y_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
              shift_q <= bus.d_in;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= COUNT;
            end
          end
          COUNT: begin
            acc_q   <= acc_q + chunk_pop;
            shift_q <= shift_q >> CHUNK_W;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) state_q <= UPDATE;
          end
          UPDATE: begin
            score_q       <= acc_q;
            score_valid_q <= 1'b1;
`ifdef POPCOUNT_TRACKER_THRESH_EN
            hit_q         <= (acc_q <= bus.thresh);
`endif
            // The first window of a frame always seeds the best; later ones must beat it.
            if ((x_q == '0 && y_q == '0) || (acc_q < best_score_q)) begin
              best_score_q <= acc_q;
              best_x_q     <= x_q;
              best_y_q     <= y_q;
            end
            if (last_x) begin
              x_q <= '0;
              if (last_y) begin
                y_q    <= '0;
                done_q <= 1'b1;
              end else begin
                y_q <= y_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.score       = score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.best_score  = best_score_q;
  assign bus.best_x      = best_x_q;
  assign bus.best_y      = best_y_q;
  assign bus.done        = done_q;
`ifdef POPCOUNT_TRACKER_THRESH_EN
  assign bus.hit         = hit_q;
`endif

endmodule

// File: tb/tb_popcount_tracker.sv
// Bench for popcount_tracker at DATA_W=16, CHUNK_W=4, 3x2 frame; scores and frame-best
// tracking are predicted by a raster model using $countones.
module tb_popcount_tracker;

  localparam int DATA_W  = 16;
  localparam int CHUNK_W = 4;
  localparam int IMG_W   = 3;
  localparam int IMG_H   = 2;
  localparam int POS_W   = 10;
  localparam int SCORE_W = $clog2(DATA_W + 1);
  localparam int N       = DATA_W / CHUNK_W;
  localparam int LAT     = N + 2;
  localparam int ONES    = (1 << SCORE_W) - 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Raster model: next window position and the best so far in this frame.
  int mx, my, mbest, mbx, mby;

  popcount_tracker_if #(.DATA_W(DATA_W), .POS_W(POS_W)) bus ();

  popcount_tracker #(
    .DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .POS_W(POS_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mx = 0; my = 0; mbest = ONES; mbx = 0; mby = 0;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin step(); w++; end
    total++;
    if (!bus.in_ready) begin bad++; $display("FAIL wait_ready: in_ready=%0b required 1", bus.in_ready); end
  endtask

  // Applies one completed window score to the model and compares every result output.
  task automatic score_window(input int s, input string tag);
    int exp_done;
    if ((mx == 0 && my == 0) || s < mbest) begin mbest = s; mbx = mx; mby = my; end
    exp_done = (mx == IMG_W - 1 && my == IMG_H - 1) ? 1 : 0;
    mx = mx + 1;
    if (mx == IMG_W) begin mx = 0; my = (my + 1) % IMG_H; end
    total++;
    if (bus.score !== SCORE_W'(s))
      begin bad++; $display("FAIL %s score: got %0d required %0d", tag, bus.score, s); end
    total++;
    if (bus.done !== exp_done[0])
      begin bad++; $display("FAIL %s done: got %0b required %0d", tag, bus.done, exp_done); end
    total++;
    if (bus.best_score !== SCORE_W'(mbest) || bus.best_x !== POS_W'(mbx) || bus.best_y !== POS_W'(mby))
      begin bad++; $display("FAIL %s best: got %0d@(%0d,%0d) required %0d@(%0d,%0d)", tag,
                            bus.best_score, bus.best_x, bus.best_y, mbest, mbx, mby); end
`ifdef POPCOUNT_TRACKER_THRESH_EN
    total++;
    if (bus.hit !== (s <= int'(bus.thresh)))
      begin bad++; $display("FAIL %s hit: got %0b required %0b", tag, bus.hit, s <= int'(bus.thresh)); end
`endif
  endtask

  // Offers one vector, counts cycles from the offer cycle to score_valid, checks the result.
  task automatic send_window(input logic [DATA_W-1:0] d, input string tag, output int lat);
    wait_ready();
    bus.d_in = d;
    bus.in_valid = 1'b1;
    lat = 0;
    step();
    lat = 1;
    bus.in_valid = 1'b0;
    bus.d_in = DATA_W'($urandom);
    while (!bus.score_valid && lat < 50) begin step(); lat++; end
    total++;
    if (!bus.score_valid) begin
      bad++; $display("FAIL %s timeout: score_valid=%0b required 1", tag, bus.score_valid);
    end else begin
      score_window($countones(d), tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %0b required 0", bus.in_ready); end
    total++;
    if (bus.score !== '0 || bus.score_valid !== 1'b0 || bus.done !== 1'b0)
      begin bad++; $display("FAIL reset outs: score=%0d sv=%0b done=%0b required 0/0/0",
                            bus.score, bus.score_valid, bus.done); end
    total++;
    if (bus.best_score !== SCORE_W'(ONES) || bus.best_x !== '0 || bus.best_y !== '0)
      begin bad++; $display("FAIL reset best: got %0d@(%0d,%0d) required %0d@(0,0)",
                            bus.best_score, bus.best_x, bus.best_y, ONES); end
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset release in_ready: got %0b required 1", bus.in_ready); end
    model_clear();
  endtask

  task automatic test_latency();
    int lat;
    send_window(16'h00F3, "latency", lat);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL latency: got %0d required %0d", lat, LAT); end
  endtask

  task automatic clear_frame();
    bus.frame_clr = 1'b1;
    step();
    bus.frame_clr = 1'b0;
    model_clear();
  endtask

  task automatic test_frame();
    logic [DATA_W-1:0] pats [6];
    int lat;
    pats = '{16'h01FF, 16'h000F, 16'h007F, 16'hF000, 16'h0003, 16'h0300};
    clear_frame();
    foreach (pats[i]) send_window(pats[i], "frame", lat);
    total++;
    if (bus.done !== 1'b1 || bus.best_score !== SCORE_W'(2) || bus.best_x !== POS_W'(1) || bus.best_y !== POS_W'(1))
      begin bad++; $display("FAIL frame end: done=%0b best=%0d@(%0d,%0d) required 1 2@(1,1)",
                            bus.done, bus.best_score, bus.best_x, bus.best_y); end
    step(); step(); step();
    total++;
    if (bus.done !== 1'b0 || bus.best_score !== SCORE_W'(2) || bus.best_x !== POS_W'(1))
      begin bad++; $display("FAIL frame hold: done=%0b best=%0d x=%0d required 0 2 1",
                            bus.done, bus.best_score, bus.best_x); end
    // Next frame's first window seeds the best even though it is worse than 2.
    send_window(16'h03FF, "frame2_first", lat);
  endtask

  task automatic test_extremes();
    int lat;
    send_window(16'hFFFF, "all_ones", lat);
    total++;
    if (bus.score !== SCORE_W'(16)) begin bad++; $display("FAIL all_ones width: got %0d required 16", bus.score); end
    send_window(16'h0000, "all_zeros", lat);
  endtask

  task automatic test_frame_clr();
    int seen;
    wait_ready();
    bus.d_in = 16'h0F0F;
    bus.in_valid = 1'b1;
    step();
    step();
    bus.frame_clr = 1'b1;
    bus.d_in = 16'hFFFF;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL frame_clr in_ready: got %0b required 0", bus.in_ready); end
    step();
    bus.frame_clr = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL frame_clr after in_ready: got %0b required 1", bus.in_ready); end
    total++;
    if (bus.best_score !== SCORE_W'(ONES) || bus.best_x !== '0 || bus.best_y !== '0)
      begin bad++; $display("FAIL frame_clr best: got %0d@(%0d,%0d) required %0d@(0,0)",
                            bus.best_score, bus.best_x, bus.best_y, ONES); end
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      if (bus.score_valid || bus.done) seen++;
      step();
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL frame_clr suppress: got %0d pulses required 0", seen); end
    model_clear();
    send_window(16'h0FFF, "post_clr", seen);
  endtask

  task automatic test_rst_mid();
    int seen;
    wait_ready();
    bus.d_in = 16'hAAAA;
    bus.in_valid = 1'b1;
    step();
    bus.d_in = 16'h5555;
    step();
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid count in_ready: got %0b required 0", bus.in_ready); end
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid in_ready: got %0b required 0", bus.in_ready); end
    step();
    total++;
    if (bus.score !== '0 || bus.score_valid !== 1'b0 || bus.best_score !== SCORE_W'(ONES) || bus.best_x !== '0)
      begin bad++; $display("FAIL rst_mid outs: score=%0d sv=%0b best=%0d x=%0d required 0 0 %0d 0",
                            bus.score, bus.score_valid, bus.best_score, bus.best_x, ONES); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid release in_ready: got %0b required 1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      if (bus.score_valid) seen++;
      step();
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_mid discard: got %0d score_valid required 0", seen); end
    model_clear();
  endtask

  task automatic test_back_to_back();
    int q[$];
    int last, cyc, nsc;
    bus.in_valid = 1'b1;
    bus.d_in = DATA_W'($urandom);
    last = -1; cyc = 0; nsc = 0;
    while ((nsc < 8 || q.size() > 0) && cyc < 300) begin
      if (bus.score_valid) begin
        if (q.size() > 0) score_window(q.pop_front(), "b2b");
        if (last >= 0) begin
          total++;
          if (cyc - last !== LAT) begin bad++; $display("FAIL b2b spacing: got %0d required %0d", cyc - last, LAT); end
        end
        last = cyc;
        nsc++;
      end
      if (nsc >= 8) bus.in_valid = 1'b0;
      if (bus.in_valid && bus.in_ready) q.push_back($countones(bus.d_in));
      step();
      cyc++;
      bus.d_in = DATA_W'($urandom);
    end
    bus.in_valid = 1'b0;
    total++;
    if (q.size() !== 0 || nsc < 8) begin bad++; $display("FAIL b2b drain: pending=%0d scores=%0d required 0 >=8", q.size(), nsc); end
  endtask

  task automatic test_random();
    int lat;
    clear_frame();
    for (int i = 0; i < 3 * IMG_W * IMG_H; i++) begin
      // Sparse vectors make equal scores common, exercising the strict-less tie rule.
      send_window(DATA_W'($urandom & $urandom & $urandom), "random", lat);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) step();
      end
    end
  endtask

`ifdef POPCOUNT_TRACKER_THRESH_EN
  task automatic test_thresh();
    int lat;
    bus.thresh = SCORE_W'(3);
    send_window(16'h000F, "thresh4", lat);
    total++;
    if (bus.hit !== 1'b0) begin bad++; $display("FAIL thresh score4 hit: got %0b required 0", bus.hit); end
    send_window(16'h0007, "thresh3", lat);
    total++;
    if (bus.hit !== 1'b1) begin bad++; $display("FAIL thresh score3 hit: got %0b required 1", bus.hit); end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.d_in = '0;
    bus.in_valid = 1'b0;
    bus.frame_clr = 1'b0;
`ifdef POPCOUNT_TRACKER_THRESH_EN
    bus.thresh = SCORE_W'(3);
`endif
    model_clear();
    test_reset();
    test_latency();
    test_frame();
    test_extremes();
    test_frame_clr();
    test_rst_mid();
    test_back_to_back();
    test_random();
`ifdef POPCOUNT_TRACKER_THRESH_EN
    test_thresh();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/popcount_tracker.md
POPCOUNT_TRACKER -- requirements
Module: popcount_tracker

Interface
REQ-001 SHALL have parameter DATA_W, default 4000, width of the XOR mismatch vector from sad.
REQ-002 SHALL have parameter CHUNK_W, default 200, bits popcounted per cycle; DATA_W divisible by CHUNK_W.
REQ-003 SHALL have parameters IMG_W, default 64, and IMG_H, default 64: window positions per line and lines per frame.
REQ-004 SHALL have parameter POS_W, default 10, position counter width; SCORE_W derived as clog2(DATA_W+1), 12 at defaults.
REQ-005 clk input 1: single clock; all logic on rising edge.
REQ-006 rst input 1: reset, synchronous and active-high.
REQ-007 d_in input DATA_W: mismatch vector (1 = differing pixel) from sad.
REQ-008 in_valid input 1: d_in valid.
REQ-009 in_ready output 1: block accepts d_in this cycle.
REQ-010 frame_clr input 1: synchronous frame restart.
REQ-011 score output SCORE_W: Hamming weight of last completed window.
REQ-012 score_valid output 1: one-cycle pulse, score updated.
REQ-013 best_score output SCORE_W; best_x, best_y outputs POS_W each: minimum score in frame and its position.
REQ-014 done output 1: one-cycle pulse after the last window of a frame.

Function
REQ-015 States SHALL be IDLE, COUNT, UPDATE; in_ready = (state==IDLE) & ~frame_clr & ~rst.
REQ-016 IDLE: on in_valid & in_ready, latch d_in into shift register, clear accumulator, clear chunk counter, go COUNT.
REQ-017 COUNT: each cycle add popcount of low CHUNK_W bits to accumulator, shift register right by CHUNK_W; after N = DATA_W/CHUNK_W cycles go UPDATE.
REQ-018 UPDATE: score <= accumulator, score_valid pulses next cycle, go IDLE; accept-to-score_valid latency SHALL be N+2 cycles, throughput one window per N+2 cycles.
REQ-019 Accumulator SHALL be SCORE_W bits; all-ones DATA_W input SHALL yield exactly DATA_W, no overflow.
REQ-020 Best update in UPDATE: at position (0,0) best_* SHALL be loaded unconditionally; elsewhere only if accumulator < best_score (strict; ties keep the earlier position).
REQ-021 Position: x increments per window; at x==IMG_W-1 x wraps to 0 and y increments; at (IMG_W-1, IMG_H-1) both wrap to 0 and done pulses coincident with score_valid.
REQ-022 best_* SHALL hold after done until the next frame's (0,0) window.
REQ-023 frame_clr SHALL abort any COUNT/UPDATE, go IDLE, zero x/y, set best_score all-ones, best_x/best_y 0, suppress score_valid/done; frame_clr wins over simultaneous in_valid (not accepted).
REQ-024 in_valid while not in_ready SHALL be ignored; d_in need not be held after acceptance.

Reset
REQ-025 rst SHALL force IDLE; score, x, y, best_x, best_y, score_valid, done = 0; best_score = all-ones; in_ready = 0 during rst, 1 the cycle after.
REQ-026 rst mid-COUNT SHALL discard the window with no score_valid.

Configuration
REQ-027 Macro POPCOUNT_TRACKER_THRESH_EN: when defined, add input thresh (SCORE_W) and output hit (1); hit pulses with score_valid when score <= thresh; reset 0.
REQ-028 Without POPCOUNT_TRACKER_THRESH_EN, thresh and hit SHALL not exist; all other behaviour identical.

Verification (DATA_W=16, CHUNK_W=4, IMG_W=3, IMG_H=2, N=4)
REQ-029 Accept d_in=16'h00F3 at cycle 0 -> score_valid at cycle 6, score=6.
REQ-030 Six windows scores 9,4,7,4,2,2 -> done with sixth score_valid; best_score=2, best_x=1, best_y=1.
REQ-031 d_in=16'hFFFF then 16'h0000 -> scores 16 then 0, no wrap.
REQ-032 frame_clr asserted in COUNT cycle 2 with in_valid high -> no score_valid, in_ready low that cycle then high; next window at (0,0) loads best.
REQ-033 rst mid-COUNT -> outputs per REQ-025, no score_valid; in_valid held during COUNT never accepted.
REQ-034 With POPCOUNT_TRACKER_THRESH_EN, thresh=3: scores 4,3 -> hit 0 then 1.
